// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: sensor sync/debounce on the divider tick, saturating occupancy, timed gate.
// Optional manual gate override is compiled in with `define GATE_MANUAL_OVERRIDE_EN.
module parking_gate_ctrl #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int DEB_SAMPLES = 4,
    parameter int GATE_TICKS  = 200
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             tick,
    input  logic             entry_sensor,
    input  logic             exit_sensor,
`ifdef GATE_MANUAL_OVERRIDE_EN
    input  logic             manual_open,
`endif
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             car_in,
    output logic             car_out,
    output logic             entry_denied,
    output logic             gate_open,
    output logic [1:0]       gate_state
);

    localparam int DW = $clog2(DEB_SAMPLES);
    localparam int TW = $clog2(GATE_TICKS + 1);

    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        OPEN   = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Index 0 = entry sensor, index 1 = exit sensor.
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         lvl;
    logic [1:0][DW-1:0] deb_cnt;
    logic [1:0]         evt;

    logic               entry_ok;
    logic               exit_ok;
    logic               deny;

    state_t             state_q;
    state_t             state_d;
    logic [TW-1:0]      timer_q;
    logic [TW-1:0]      timer_d;
    logic               accept;
    logic               sensor_any;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            lvl     <= '0;
            deb_cnt <= '0;
            evt     <= '0;
        end else begin
            sync1 <= {exit_sensor, entry_sensor};
            sync2 <= sync1;
            evt   <= '0;
            if (tick) begin
                for (int i = 0; i < 2; i++) begin
                    if (sync2[i] == lvl[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] == DW'(DEB_SAMPLES - 1)) begin
                        lvl[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                        evt[i]     <= sync2[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Both events are judged against the pre-update count; the net change is applied.
    assign entry_ok = evt[0] & ~full;
    assign deny     = evt[0] & full;
    assign exit_ok  = evt[1] & ~empty;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            occupancy    <= '0;
            car_in       <= 1'b0;
            car_out      <= 1'b0;
            entry_denied <= 1'b0;
        end else begin
            car_in       <= entry_ok;
            car_out      <= exit_ok;
            entry_denied <= deny;
            case ({entry_ok, exit_ok})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign full  = (occupancy == CNT_W'(CAPACITY));
    assign empty = (occupancy == '0);

`ifdef GATE_MANUAL_OVERRIDE_EN
    logic [1:0] man_sync;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            man_sync <= '0;
        end else begin
            man_sync <= {man_sync[0], manual_open};
        end
    end
`endif

    assign accept     = car_in | car_out;
    assign sensor_any = |lvl;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            CLOSED: begin
                if (accept) begin
                    state_d = OPEN;
                    timer_d = TW'(GATE_TICKS);
                end
            end
            OPEN: begin
                if (accept) begin
                    timer_d = TW'(GATE_TICKS);
                end else if (tick) begin
                    if (timer_q <= TW'(1)) begin
                        timer_d = '0;
                        state_d = sensor_any ? HOLD : CLOSED;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    state_d = OPEN;
                    timer_d = TW'(GATE_TICKS);
                end else if (!sensor_any) begin
                    state_d = CLOSED;
                end
            end
            default: begin
                state_d = CLOSED;
                timer_d = '0;
            end
        endcase
`ifdef GATE_MANUAL_OVERRIDE_EN
        if (man_sync[1]) begin
            state_d = OPEN;
            timer_d = TW'(GATE_TICKS);
        end
`endif
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= CLOSED;
            timer_q   <= '0;
            gate_open <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
`ifdef GATE_MANUAL_OVERRIDE_EN
            gate_open <= (state_q != CLOSED) | man_sync[1];
`else
            gate_open <= (state_q != CLOSED);
`endif
        end
    end

    assign gate_state = state_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed vector table, hand-written corner sequences,
// then random sensor activity checked against a tick-level reference model.
module tb_parking_gate_ctrl;

    localparam int CAPACITY = 8;
    localparam int CNT_W    = 4;
    localparam int DEB      = 4;
    localparam int GT       = 200;

    // ---------------- clock / reset ----------------
    logic             clk_in;
    logic             reset;
    logic             tick;
    logic             entry_sensor;
    logic             exit_sensor;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             car_in;
    logic             car_out;
    logic             entry_denied;
    logic             gate_open;
    logic [1:0]       gate_state;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    parking_gate_ctrl #(
        .CAPACITY(CAPACITY), .CNT_W(CNT_W), .DEB_SAMPLES(DEB), .GATE_TICKS(GT)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .tick(tick),
        .entry_sensor(entry_sensor),
        .exit_sensor(exit_sensor),
`ifdef GATE_MANUAL_OVERRIDE_EN
        .manual_open(1'b0),
`endif
        .occupancy(occupancy),
        .full(full),
        .empty(empty),
        .car_in(car_in),
        .car_out(car_out),
        .entry_denied(entry_denied),
        .gate_open(gate_open),
        .gate_state(gate_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int tot_in = 0, tot_out = 0, tot_deny = 0;
    int seen_in = 0, seen_out = 0, seen_deny = 0;

    // Every high cycle counts, so a pulse that lasts two cycles shows up as two.
    always @(negedge clk_in) begin
        if (car_in)       tot_in++;
        if (car_out)      tot_out++;
        if (entry_denied) tot_deny++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag, input int exp_occ, input int exp_in,
                             input int exp_out, input int exp_deny, input int exp_gate);
        chk({tag, ".occupancy"}, int'(occupancy), exp_occ);
        chk({tag, ".full"}, int'(full), (exp_occ == CAPACITY) ? 1 : 0);
        chk({tag, ".empty"}, int'(empty), (exp_occ == 0) ? 1 : 0);
        chk({tag, ".car_in"}, tot_in - seen_in, exp_in);
        chk({tag, ".car_out"}, tot_out - seen_out, exp_out);
        chk({tag, ".entry_denied"}, tot_deny - seen_deny, exp_deny);
        chk({tag, ".gate_open"}, int'(gate_open), exp_gate);
        seen_in   = tot_in;
        seen_out  = tot_out;
        seen_deny = tot_deny;
    endtask

    // ---------------- driver tasks ----------------
    // One tick period: sensors set, two cycles to synchronise, tick, three cycles to settle.
    task automatic run_period(input bit en, input bit ex);
        entry_sensor = en;
        exit_sensor  = ex;
        tick         = 1'b0;
        repeat (2) @(negedge clk_in);
        tick = 1'b1;
        @(negedge clk_in);
        tick = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
    endtask

    task automatic hold_periods(input bit en, input bit ex, input int n);
        for (int i = 0; i < n; i++) run_period(en, ex);
    endtask

    task automatic apply_reset();
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        tick         = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        #1;
        seen_in   = tot_in;
        seen_out  = tot_out;
        seen_deny = tot_deny;
    endtask

    // ---------------- reference model (tick level) ----------------
    bit m_lvl_in, m_lvl_out;
    bit h_in[$];
    bit h_out[$];
    int m_occ, m_rem;
    bit m_hold;
    int e_in, e_out, e_deny, e_gate;

    function automatic bit settled(input bit h[$], input bit lvl);
        if (h.size() < DEB) return 1'b0;
        foreach (h[i]) if (h[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_lvl_in = 0; m_lvl_out = 0;
        h_in.delete(); h_out.delete();
        m_occ = 0; m_rem = 0; m_hold = 0;
    endtask

    task automatic model_period(input bit en, input bit ex);
        bit old_any, rise_in, rise_out;
        old_any = m_lvl_in | m_lvl_out;
        h_in.push_back(en);
        h_out.push_back(ex);
        if (h_in.size() > DEB) void'(h_in.pop_front());
        if (h_out.size() > DEB) void'(h_out.pop_front());
        rise_in  = 0;
        rise_out = 0;
        if (settled(h_in, m_lvl_in)) begin
            m_lvl_in = !m_lvl_in;
            rise_in  = m_lvl_in;
        end
        if (settled(h_out, m_lvl_out)) begin
            m_lvl_out = !m_lvl_out;
            rise_out  = m_lvl_out;
        end
        e_in   = (rise_in && m_occ < CAPACITY) ? 1 : 0;
        e_deny = (rise_in && m_occ == CAPACITY) ? 1 : 0;
        e_out  = (rise_out && m_occ > 0) ? 1 : 0;
        m_occ  = m_occ + e_in - e_out;
        // Gate: countdown in ticks; at expiry it lingers while a car is over a sensor.
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && old_any) m_hold = 1;
        end
        if (m_hold && !(m_lvl_in | m_lvl_out)) m_hold = 0;
        if (e_in + e_out > 0) begin
            m_rem  = GT;
            m_hold = 0;
        end
        e_gate = (m_rem > 0 || m_hold) ? 1 : 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit en;
        bit ex;
        int occ;
        int p_in;
        int p_out;
        int p_deny;
        int gate;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit en, input bit ex, input int occ, input int p_in,
                           input int p_out, input int p_deny, input int gate);
        vec_t v;
        v.en = en; v.ex = ex; v.occ = occ;
        v.p_in = p_in; v.p_out = p_out; v.p_deny = p_deny; v.gate = gate;
        vecs.push_back(v);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit en, ex;
        string tag;

        // Glitch: three high ticks then low -> nothing.
        add_vec(1, 0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0);
        // Four high ticks -> one car in, gate opens.
        add_vec(1, 0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) add_vec(0, 0, 1, 0, 0, 0, 1);
        // Exit accepted at occupancy 1.
        for (int i = 0; i < 3; i++) add_vec(0, 1, 1, 0, 0, 0, 1);
        add_vec(0, 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 0, 0, 1);
        // Exit at empty is ignored.
        for (int i = 0; i < 4; i++) add_vec(0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 0, 0, 1);

        reset = 1'b1;
        tick = 1'b0;
        entry_sensor = 1'b0;
        exit_sensor = 1'b0;
        repeat (2) @(negedge clk_in);
        #1;
        chk("reset.occupancy", int'(occupancy), 0);
        chk("reset.full", int'(full), 0);
        chk("reset.empty", int'(empty), 1);
        chk("reset.pulses", int'({car_in, car_out, entry_denied}), 0);
        chk("reset.gate_open", int'(gate_open), 0);
        chk("reset.gate_state", int'(gate_state), 0);
        @(negedge clk_in);
        reset = 1'b0;
        #1;

        foreach (vecs[i]) begin
            run_period(vecs[i].en, vecs[i].ex);
            $sformat(tag, "vec%0d", i);
            chk_state(tag, vecs[i].occ, vecs[i].p_in, vecs[i].p_out, vecs[i].p_deny, vecs[i].gate);
        end

        // Fill to capacity.
        for (int k = 1; k <= CAPACITY; k++) begin
            hold_periods(1, 0, 3);
            run_period(1, 0);
            chk_state("fill", k, 1, 0, 0, 1);
            hold_periods(0, 0, 4);
        end
        hold_periods(0, 0, GT + 1);
        chk_state("fill_idle", CAPACITY, 0, 0, 0, 0);
        hold_periods(1, 0, 4);
        chk_state("ninth_entry", CAPACITY, 0, 0, 1, 0);
        hold_periods(0, 0, 4);

        // Simultaneous at full: entry denied, exit accepted.
        hold_periods(1, 1, 4);
        chk_state("simul_full", CAPACITY - 1, 0, 1, 1, 1);
        hold_periods(0, 0, 4);

        for (int k = CAPACITY - 2; k >= 3; k--) begin
            hold_periods(0, 1, 4);
            chk_state("drain", k, 0, 1, 0, 1);
            hold_periods(0, 0, 4);
        end
        hold_periods(1, 1, 4);
        chk_state("simul_mid", 3, 1, 1, 0, 1);
        hold_periods(0, 0, 4);

        // Gate closes exactly GT ticks after the last accepted event.
        hold_periods(0, 0, GT + 1);
        chk_state("gate_idle", 3, 0, 0, 0, 0);
        hold_periods(1, 0, 4);
        chk_state("gate_open", 4, 1, 0, 0, 1);
        hold_periods(0, 0, GT - 1);
        chk_state("gate_last_tick", 4, 0, 0, 0, 1);
        run_period(0, 0);
        chk_state("gate_closed", 4, 0, 0, 0, 0);

        // Exit sensor held through the timeout -> HOLD until it debounces low.
        hold_periods(0, 1, 4);
        chk_state("hold_exit", 3, 0, 1, 0, 1);
        hold_periods(0, 1, GT);
        chk_state("hold_timeout", 3, 0, 0, 0, 1);
        chk("hold.gate_state", int'(gate_state), 2);
        hold_periods(0, 0, 3);
        chk_state("hold_bounce", 3, 0, 0, 0, 1);
        run_period(0, 0);
        chk_state("hold_release", 3, 0, 0, 0, 0);
        chk("release.gate_state", int'(gate_state), 0);

        // Reach occupancy 5 with the gate open, then reset mid-cycle.
        hold_periods(1, 0, 4);
        chk_state("pre_reset_a", 4, 1, 0, 0, 1);
        hold_periods(0, 0, 4);
        hold_periods(1, 0, 4);
        chk_state("pre_reset_b", 5, 1, 0, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset.occupancy", int'(occupancy), 0);
        chk("midreset.full", int'(full), 0);
        chk("midreset.empty", int'(empty), 1);
        chk("midreset.pulses", int'({car_in, car_out, entry_denied}), 0);
        chk("midreset.gate_open", int'(gate_open), 0);
        chk("midreset.gate_state", int'(gate_state), 0);
        apply_reset();
        hold_periods(0, 0, 10);
        chk_state("post_reset", 0, 0, 0, 0, 0);

        // Random sensor activity against the model.
        apply_reset();
        model_reset();
        en = 0;
        ex = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) en = !en;
            if ($urandom_range(0, 3) == 0) ex = !ex;
            run_period(en, ex);
            model_period(en, ex);
            $sformat(tag, "rand%0d", i);
            chk_state(tag, m_occ, e_in, e_out, e_deny, e_gate);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
